rr_arb: RTL and testbench
=========================

RR_ARB -- requirements
Module: rr_arb

Interface
REQ-001 Parameter N, default 4: number of requesters; SHALL be a power of two, >= 2.
REQ-002 Parameter MAX_HOLD, default 8: maximum grant tenure in cycles (used only with RR_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N  per-requester request; held high for the whole tenure, dropped to release.
REQ-006 gnt  output  N  registered one-hot grant, or all-zero.
REQ-007 any_gnt  output  1  registered; high iff gnt != 0.
REQ-008 owner  output  log2(N)  registered index of the granted requester; holds the last owner when gnt == 0.
REQ-009 timeout  output  1  one-cycle pulse on a forced release; tied 0 when RR_ARB_TIMEOUT_EN is undefined.

Function
REQ-010 Priority pointer ptr (log2(N) bits) SHALL select the search start: the candidate is the first requesting index found scanning ptr, ptr+1, ... wrapping modulo N.
REQ-011 Two states SHALL exist: IDLE (gnt == 0) and GRANT (exactly one gnt bit high).
REQ-012 IDLE: if req != 0, the next cycle SHALL enter GRANT with gnt = one-hot(candidate); latency is exactly one cycle from req to gnt.
REQ-013 On every grant issue, ptr SHALL load (granted index + 1) mod N; index N-1 wraps to 0.
REQ-014 GRANT: while req[owner] is high (and no timeout), gnt, owner and ptr SHALL hold unchanged regardless of other req bits.
REQ-015 GRANT, req[owner] low (release): if any other req is high, the next cycle SHALL grant the candidate from ptr with no idle cycle (stay in GRANT); else gnt = 0 and state returns to IDLE.
REQ-016 Requests asserting in the same cycle as a release SHALL be eligible in that arbitration.
REQ-017 A requester SHALL never see gnt without its req having been high in the preceding cycle.
REQ-018 Requests rising or falling for non-owners during GRANT SHALL have no effect on the grant.

Reset
REQ-019 rst high SHALL immediately force state = IDLE, gnt = 0, any_gnt = 0, owner = 0, ptr = 0, timeout = 0, hold counter = 0, including mid-tenure.
REQ-020 After rst deasserts, the first arbitration SHALL start from ptr = 0.

Configuration
REQ-021 Macro RR_ARB_TIMEOUT_EN defined: a hold counter SHALL count GRANT cycles of the current owner; on the cycle the tenure reaches MAX_HOLD, release SHALL be forced as in REQ-015, with req[owner] masked for that single arbitration, and timeout pulses high for one cycle.
REQ-022 With the forced release and no other requester, gnt SHALL go 0 for one cycle (IDLE), after which the still-requesting owner is re-granted normally.
REQ-023 Macro undefined: no hold counter is built, tenure is unbounded, timeout is constant 0.

Structure
REQ-024 Package rr_arb_pkg SHALL hold the state enum (IDLE, GRANT), the default N and MAX_HOLD constants and the pointer-width function.
REQ-025 The candidate search SHALL be the existing programmable priority encoder pp_enc (inputs: pointer, masked req; outputs: one-hot gnt, any_gnt), instantiated once and combinational; rr_arb adds only the registers and FSM.

Verification (N=4, MAX_HOLD=8)
REQ-026 rst=1 mid-tenure with gnt=0100 -> gnt=0000, any_gnt=0, owner=0, ptr=0 in the same cycle, without waiting for clk.
REQ-027 From reset, req=1010 -> next cycle gnt=0010, owner=1; drop req[1] -> next cycle gnt=1000, owner=3; drop req[3] -> gnt=0000, IDLE.
REQ-028 req=1111, each owner releases for one cycle after 2 cycles of tenure -> grant order 0,1,2,3,0, with no idle cycle between grants.
REQ-029 Wrap: grant to index 3 -> ptr=0; then req=0011 -> next grant 0001.
REQ-030 RR_ARB_TIMEOUT_EN, req=0001 held -> gnt=0001 for 8 cycles, timeout pulse, gnt=0000 for one cycle, then gnt=0001 again; with req=0011 held -> grants alternate 0001/0010 every 8 cycles, with no idle cycle.
REQ-031 Without the macro, same req=0001 held for 100 cycles -> gnt stays 0001, timeout stays 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
package rr_arb_pkg;

  // Arbiter FSM states: IDLE means no grant is held, GRANT means exactly one is held.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  // Width of the priority pointer and the owner index. It is never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_pp_enc.sv
// Programmable priority encoder (pp_enc). It returns the first requester at or after
// ptr, wrapping modulo N, as a one-hot vector. The block is purely combinational.
module pp_enc
  import rr_arb_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [ptr_width(N)-1:0] ptr,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            gnt,
  output logic                    any_gnt
);

  localparam int PW = ptr_width(N);

  logic [N-1:0]  w_rot;
  logic [PW-1:0] w_off;
  logic          w_found;
  logic [PW-1:0] w_idx;

  // Rotate the requests so that index 0 of w_rot is the requester at ptr.
  // N is a power of two, so truncating the sum performs the modulo.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot[gi] = req[ptr + PW'(gi)];
    end
  endgenerate

  // Fixed-priority search on the rotated vector: the lowest offset wins.
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = PW'(i);
      end
    end
  end

  assign w_idx   = ptr + w_off;
  assign gnt     = w_found ? (N'(1) << w_idx) : '0;
  assign any_gnt = w_found;

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with registered grant outputs.
// Optional build macro RR_ARB_TIMEOUT_EN limits each grant tenure to MAX_HOLD cycles.
module rr_arb
  import rr_arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            gnt,
  output logic                    any_gnt,
  output logic [ptr_width(N)-1:0] owner,
  output logic                    timeout
);

  localparam int PW = ptr_width(N);

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic          r_any;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_ptr;

  logic [N-1:0]  w_req_m;
  logic [N-1:0]  w_cand;
  logic          w_cand_any;
  logic [PW-1:0] w_cand_idx;
  logic          w_owner_req;
  logic          w_expire;
  logic          w_keep;

  // Mask the current owner out of arbitration. On a normal release its request is
  // already low. On a forced release the mask keeps the owner from winning again at once.
  // In IDLE r_gnt is zero, so nothing is masked.
  assign w_req_m     = req & ~r_gnt;
  assign w_owner_req = req[r_owner];
  assign w_keep      = (r_state == GRANT) && w_owner_req && !w_expire;

  pp_enc #(.N(N)) u_pp_enc (
    .ptr     (r_ptr),
    .req     (w_req_m),
    .gnt     (w_cand),
    .any_gnt (w_cand_any)
  );

  // Convert the one-hot candidate to its index for owner and for the pointer update.
  always_comb begin
    w_cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_cand_idx = PW'(i);
    end
  end

  // Arbiter FSM: hold the grant while the owner keeps requesting; otherwise re-arbitrate or go idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_any   <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else if (w_keep) begin
      r_state <= GRANT;
    end else if (w_cand_any) begin
      r_state <= GRANT;
      r_gnt   <= w_cand;
      r_any   <= 1'b1;
      r_owner <= w_cand_idx;
      r_ptr   <= w_cand_idx + PW'(1);
    end else begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_any   <= 1'b0;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic          r_timeout;

  // The counter value is the number of cycles gnt has been visible to the current owner.
  assign w_expire = (r_state == GRANT) && (r_hold == HW'(MAX_HOLD));

  // Track tenure length and flag releases that were forced on a still-requesting owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire && w_owner_req;
      if (w_keep)          r_hold <= r_hold + HW'(1);
      else if (w_cand_any) r_hold <= HW'(1);
      else                 r_hold <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign gnt     = r_gnt;
  assign any_gnt = r_any;
  assign owner   = r_owner;

endmodule

// File: tb/tb_rr_arb.sv
// Testbench for rr_arb with N=4 and MAX_HOLD=8. It checks the timeout scenario when
// RR_ARB_TIMEOUT_EN is defined and the unbounded tenure otherwise.
module tb_rr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       any_gnt;
  logic [1:0] owner;
  logic       timeout;

  typedef struct packed {
    logic [3:0] gnt;
    logic       any;
    logic [1:0] owner;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_arb #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .any_gnt (any_gnt),
    .owner   (owner),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reset state, checked asynchronously before any clock edge.
  task automatic test_reset();
    exp_t e, got;
    #3;
    sb_q.push_back(exp_t'(8'b0000_0_00_0));
    got = {gnt, any_gnt, owner, timeout};
    e = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", got, e);
    end
    n_cmp++;
    if (dut.r_ptr !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Basic grants, hand-off, idle, pointer wrap and non-owner insensitivity.
  task automatic test_basic();
    logic [11:0] rows [9];
    exp_t e, got;
    do_reset();
    rows = '{
      {4'b1010, 4'b0010, 1'b1, 2'd1, 1'b0},
      {4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0},
      {4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0},
      {4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0},
      {4'b0111, 4'b0001, 1'b1, 2'd0, 1'b0},
      {4'b0101, 4'b0001, 1'b1, 2'd0, 1'b0},
      {4'b1100, 4'b0100, 1'b1, 2'd2, 1'b0},
      {4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0},
      {4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0}
    };
    foreach (rows[i]) begin
      req = rows[i][11:8];
      sb_q.push_back(exp_t'(rows[i][7:0]));
      @(posedge clk);
      #1;
      got = {gnt, any_gnt, owner, timeout};
      e = sb_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL basic row %0d: got gnt=%b any=%b owner=%0d to=%b want gnt=%b any=%b owner=%0d to=%b",
                 i, got.gnt, got.any, got.owner, got.to, e.gnt, e.any, e.owner, e.to);
      end
    end
  endtask

  // All four request; each owner drops its request for one cycle after two cycles of tenure.
  task automatic test_back_to_back();
    logic [11:0] rows [10];
    exp_t e, got;
    do_reset();
    rows = '{
      {4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0},
      {4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0},
      {4'b1110, 4'b0010, 1'b1, 2'd1, 1'b0},
      {4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0},
      {4'b1101, 4'b0100, 1'b1, 2'd2, 1'b0},
      {4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0},
      {4'b1011, 4'b1000, 1'b1, 2'd3, 1'b0},
      {4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0},
      {4'b0111, 4'b0001, 1'b1, 2'd0, 1'b0},
      {4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    foreach (rows[i]) begin
      req = rows[i][11:8];
      sb_q.push_back(exp_t'(rows[i][7:0]));
      @(posedge clk);
      #1;
      got = {gnt, any_gnt, owner, timeout};
      e = sb_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL rotation row %0d: got gnt=%b owner=%0d any=%b to=%b want gnt=%b owner=%0d any=%b to=%b",
                 i, got.gnt, got.owner, got.any, got.to, e.gnt, e.owner, e.any, e.to);
      end
    end
  endtask

  // Assert reset in the middle of a tenure, then confirm arbitration restarts from pointer 0.
  task automatic test_reset_mid();
    exp_t e, got;
    do_reset();
    req = 4'b0100;
    sb_q.push_back(exp_t'({4'b0100, 1'b1, 2'd2, 1'b0}));
    @(posedge clk);
    #1;
    got = {gnt, any_gnt, owner, timeout};
    e = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL midrst_pre: got %b want %b", got, e);
    end
    #2 rst = 1'b1;
    sb_q.push_back(exp_t'(8'b0000_0_00_0));
    #1;
    got = {gnt, any_gnt, owner, timeout};
    e = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL midrst_async: got %b want %b", got, e);
    end
    n_cmp++;
    if (dut.r_ptr !== 2'd0) begin
      n_bad++;
      $display("FAIL midrst_ptr: got %0d want 0", dut.r_ptr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req = 4'b1100;
    sb_q.push_back(exp_t'({4'b0100, 1'b1, 2'd2, 1'b0}));
    @(posedge clk);
    #1;
    got = {gnt, any_gnt, owner, timeout};
    e = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL midrst_first_arb: got %b want %b", got, e);
    end
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  // A single holder is forced out after 8 cycles. Two holders alternate every 8 cycles.
  task automatic test_timeout();
    exp_t e, got;
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      if (k < 8)       sb_q.push_back(exp_t'({4'b0001, 1'b1, 2'd0, 1'b0}));
      else if (k == 8) sb_q.push_back(exp_t'({4'b0000, 1'b0, 2'd0, 1'b1}));
      else             sb_q.push_back(exp_t'({4'b0001, 1'b1, 2'd0, 1'b0}));
      @(posedge clk);
      #1;
      got = {gnt, any_gnt, owner, timeout};
      e = sb_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL timeout_single cyc %0d: got %b want %b", k, got, e);
      end
    end
    req = 4'b0011;
    for (int k = 0; k < 24; k++) begin
      if (((k + 1) / 8) % 2 == 1)
        sb_q.push_back(exp_t'({4'b0010, 1'b1, 2'd1, ((k + 1) % 8 == 0)}));
      else
        sb_q.push_back(exp_t'({4'b0001, 1'b1, 2'd0, ((k + 1) % 8 == 0)}));
      @(posedge clk);
      #1;
      got = {gnt, any_gnt, owner, timeout};
      e = sb_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL timeout_alt cyc %0d: got %b want %b", k, got, e);
      end
    end
    req = 4'b0000;
  endtask
`else
  // Without the timeout feature, a held request keeps its grant indefinitely.
  task automatic test_no_timeout();
    exp_t e, got;
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      sb_q.push_back(exp_t'({4'b0001, 1'b1, 2'd0, 1'b0}));
      @(posedge clk);
      #1;
      got = {gnt, any_gnt, owner, timeout};
      e = sb_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL no_timeout cyc %0d: got %b want %b", k, got, e);
      end
    end
    req = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
